// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of a slow clock (clk_meas)
// in clk cycles, with lock indication and a no-edge timeout.
//   clk, rst_n      : sampling clock, async active-low reset
//   en              : measurement enable (low forces IDLE)
//   clk_meas        : clock under measurement, asynchronous to clk
//   period_out      : last measured rise-to-rise period
//   high_out        : synchronized high cycles within that period
//   meas_valid      : one-cycle pulse when period_out/high_out update
//   timeout         : one-cycle pulse when no rise seen for TIMEOUT cycles
//   locked          : high while measuring
module clk_period_meter #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clk_meas,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             timeout,
    output logic             locked
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SYNC = 2'd1;
    localparam logic [1:0] S_MEAS = 2'd2;

    localparam logic [CNT_W-1:0] LP_TO  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

    logic [1:0]       r_state;
    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [CNT_W-1:0] r_pcnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic             r_valid;
    logic             r_tout;

    logic             w_rise;
    logic             w_hit;
    logic [CNT_W-1:0] w_hinc;

    // r_s2 is the synchronized level, r_s3 its one-cycle-delayed copy
    assign w_rise = r_s2 & ~r_s3;
    assign w_hit  = (r_pcnt == LP_TO);
    assign w_hinc = {{(CNT_W-1){1'b0}}, r_s2};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= clk_meas;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_pcnt   <= '0;
            r_hcnt   <= '0;
            r_period <= '0;
            r_high   <= '0;
            r_valid  <= 1'b0;
            r_tout   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_tout  <= 1'b0;
            if (!en) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_SYNC;
                        r_pcnt  <= '0;
                        r_hcnt  <= '0;
                    end
                    S_SYNC: begin
                        // a rise wins over an expiring wait counter
                        if (w_rise) begin
                            r_state <= S_MEAS;
                            r_pcnt  <= LP_ONE;
                            r_hcnt  <= LP_ONE;
                        end else if (w_hit) begin
                            r_tout <= 1'b1;
                            r_pcnt <= '0;
                            r_hcnt <= '0;
                        end else begin
                            r_pcnt <= r_pcnt + LP_ONE;
                        end
                    end
                    S_MEAS: begin
                        if (w_rise) begin
                            r_period <= r_pcnt;
                            r_high   <= r_hcnt;
                            r_valid  <= 1'b1;
                            r_pcnt   <= LP_ONE;
                            r_hcnt   <= LP_ONE;
                        end else if (w_hit) begin
                            r_tout  <= 1'b1;
                            r_state <= S_SYNC;
                            r_pcnt  <= '0;
                            r_hcnt  <= '0;
                        end else begin
                            r_pcnt <= r_pcnt + LP_ONE;
                            r_hcnt <= r_hcnt + w_hinc;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign period_out = r_period;
    assign high_out   = r_high;
    assign meas_valid = r_valid;
    assign timeout    = r_tout;
    assign locked     = (r_state == S_MEAS);

endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: randomized scoreboard bench for clk_period_meter.
// The reference model works on the per-edge sample history of clk_meas.
module tb_clk_period_meter;

    localparam int CW = 16;
    localparam int TO = 20;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          clk_meas;
    logic [CW-1:0] period_out;
    logic [CW-1:0] high_out;
    logic          meas_valid;
    logic          timeout;
    logic          locked;

    clk_period_meter #(
        .CNT_W(CW),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .clk_meas(clk_meas),
        .period_out(period_out),
        .high_out(high_out),
        .meas_valid(meas_valid),
        .timeout(timeout),
        .locked(locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int p;
        int h;
        int cyc;
    } ev_t;

    ev_t q[$];
    ev_t mon_e;
    int  n_chk = 0;
    int  n_fail = 0;
    bit  hist[0:19999];
    int  k = 4;
    int  last_k = 0;
    int  last = -1;
    int  sync_start = 0;
    bit  prev_en = 1'b0;
    int  exp_p = 0;
    int  exp_h = 0;
    bit  exp_lock = 1'b0;
    int  ph = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int ones(input int a, input int b);
        int s = 0;
        for (int i = a; i <= b; i++) s += int'(hist[i]);
        return s;
    endfunction

    task automatic push(input int kind, input int p, input int h);
        ev_t e;
        e.kind = kind;
        e.p    = p;
        e.h    = h;
        e.cyc  = k;
        q.push_back(e);
    endtask

    // One clk edge of the reference: a rise is a 0->1 step in the sample
    // history seen two edges late; periods/high times come from index math.
    task automatic model_step(input bit m, input bit e);
        bit rise;
        hist[k] = m;
        last_k  = k;
        rise    = hist[k-2] && !hist[k-3];
        if (!e) begin
            prev_en = 1'b0;
            last    = -1;
        end else if (!prev_en) begin
            prev_en    = 1'b1;
            sync_start = k;
            last       = -1;
        end else if (last >= 0) begin
            if (rise) begin
                exp_p = k - last;
                exp_h = ones(last - 2, k - 3);
                push(0, exp_p, exp_h);
                last = k;
            end else if (k - last == TO) begin
                push(1, 0, 0);
                last       = -1;
                sync_start = k;
            end
        end else begin
            if (rise) begin
                last = k;
            end else if (k - sync_start == TO + 1) begin
                push(1, 0, 0);
                sync_start = k;
            end
        end
        exp_lock = (last >= 0);
        k++;
    endtask

    task automatic cyc(input bit m, input bit e);
        clk_meas = m;
        en       = e;
        @(posedge clk);
        model_step(m, e);
        @(negedge clk);
    endtask

    task automatic wave(input int hi, input int lo, input int n, input bit e);
        if (ph >= hi + lo) ph = 0;
        repeat (n) begin
            cyc(ph < hi, e);
            ph = (ph + 1) % (hi + lo);
        end
    endtask

    task automatic stuck(input bit v, input int n);
        repeat (n) cyc(v, 1'b1);
    endtask

    task automatic chk_zero();
        chk("rst_period", int'(period_out), 0);
        chk("rst_high", int'(high_out), 0);
        chk("rst_valid", int'(meas_valid), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_locked", int'(locked), 0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 chk_zero();
        q.delete();
        last     = -1;
        prev_en  = 1'b0;
        exp_p    = 0;
        exp_h    = 0;
        exp_lock = 1'b0;
        hist[k-1] = 1'b0;
        hist[k-2] = 1'b0;
        hist[k-3] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("locked", int'(locked), int'(exp_lock));
            chk("period_out", int'(period_out), exp_p);
            chk("high_out", int'(high_out), exp_h);
            chk("excl", int'(meas_valid & timeout), 0);
            if (meas_valid || timeout) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL pulse: got v=%0b t=%0b expected none (edge %0d)",
                             meas_valid, timeout, last_k);
                end else begin
                    mon_e = q.pop_front();
                    chk("kind", int'(timeout), mon_e.kind);
                    chk("edge", last_k, mon_e.cyc);
                    if (mon_e.kind == 0) begin
                        chk("valid_p", int'(period_out), mon_e.p);
                        chk("valid_h", int'(high_out), mon_e.h);
                    end
                end
            end else if (q.size() > 0 && q[0].cyc <= last_k) begin
                n_chk++;
                n_fail++;
                $display("FAIL missing: got no pulse expected kind %0d (edge %0d)",
                         q[0].kind, q[0].cyc);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        int hi;
        int lo;
        int r;
        rst_n    = 1'b0;
        en       = 1'b1;
        clk_meas = 1'b0;
        #1 chk_zero();
        @(negedge clk);
        rst_n = 1'b1;
        ph = 0;
        wave(2, 2, 40, 1'b1);
        ph = 0;
        wave(3, 4, 60, 1'b1);
        ph = 0;
        wave(2, 2, 20, 1'b1);
        wave(3, 3, 40, 1'b1);
        stuck(1'b0, 50);
        wave(2, 2, 30, 1'b1);
        wave(3, 3, 4, 1'b1);
        wave(3, 3, 5, 1'b0);
        wave(3, 3, 40, 1'b1);
        wave(2, 3, 13, 1'b1);
        do_reset();
        wave(2, 3, 30, 1'b1);
        for (int it = 0; it < 60; it++) begin
            hi = $urandom_range(1, 6);
            lo = $urandom_range(1, 6);
            r  = $urandom_range(0, 9);
            if (r == 0) wave(hi, lo, $urandom_range(1, 8), 1'b0);
            else if (r == 1) do_reset();
            else if (r == 2) stuck(1'($urandom_range(0, 1)), $urandom_range(15, 50));
            wave(hi, lo, $urandom_range(5, 60), 1'b1);
        end
        cyc(1'b0, 1'b1);
        #1 chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_period_meter.md
CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 Parameter CNT_W, default 16: width of the period and high-time counters and outputs.
REQ-002 Parameter TIMEOUT, default 1000: clk cycles without a detected rising edge before a timeout is declared; range 2 to 2^CNT_W-1.
REQ-003 Port clk, input, 1: sole clock; all state updates occur on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous assertion, active-low.
REQ-005 Port en, input, 1: measurement enable; when low, the block stays in IDLE.
REQ-006 Port clk_meas, input, 1: divided or slow clock under measurement, asynchronous to clk.
REQ-007 Port period_out, output, CNT_W: last measured period, in clk cycles.
REQ-008 Port high_out, output, CNT_W: clk cycles during which synchronized clk_meas was high in that period.
REQ-009 Port meas_valid, output, 1: one-cycle pulse when period_out and high_out update.
REQ-010 Port timeout, output, 1: one-cycle pulse when TIMEOUT expires.
REQ-011 Port locked, output, 1: high while in MEASURE.

Function
REQ-012 clk_meas shall pass through a 2-flop synchronizer followed by a registered copy; a rise shall be detected when the synchronized value is 1 and the delayed copy is 0.
REQ-013 Latency shall be 3 clk edges from a clk_meas transition to the detection cycle.
REQ-014 FSM states: IDLE, SYNC (wait for first rise), MEASURE.
REQ-015 IDLE -> SYNC when en=1; any state -> IDLE when en=0, taking effect on the next clk edge.
REQ-016 SYNC -> MEASURE on a detected rise; period counter loads 1 and high counter loads 1; no meas_valid.
REQ-017 In MEASURE, each cycle without a rise: period counter +1; high counter +1 if synchronized clk_meas=1.
REQ-018 In MEASURE on a detected rise: period_out <= period counter, high_out <= high counter, meas_valid=1 for exactly that cycle; both counters reload 1.
REQ-019 Result: a rise-to-rise spacing of N clk cycles yields period_out=N; high_out equals the high cycles in that interval, so 1 <= high_out <= N-1 for a toggling input.
REQ-020 When the period counter equals TIMEOUT with no rise in SYNC or MEASURE: timeout=1 for one cycle; go to SYNC; counters clear; period_out and high_out hold their last values.
REQ-021 The SYNC wait counter shall also start at the SYNC entry cycle and reset on every rise.
REQ-022 A rise detected in the same cycle the counter reaches TIMEOUT shall count as a rise; no timeout fires.
REQ-023 Counters shall never wrap; TIMEOUT bounds them.
REQ-024 When en falls: meas_valid and timeout are 0 from the next cycle; the synchronizer keeps running; outputs hold.
REQ-025 locked=1 exactly in MEASURE.
REQ-026 meas_valid and timeout are never both 1.

Reset
REQ-027 With rst_n=0, all of the following shall hold immediately, independent of clk: state=IDLE, synchronizer flops=0, counters=0, period_out=0, high_out=0, meas_valid=0, timeout=0, locked=0.
REQ-028 After rst_n rises, an en=1 already present shall move IDLE -> SYNC on the first clk edge.
REQ-029 Reset asserted mid-measurement shall discard the partial count; the first meas_valid after release shall need two fresh rises.

Verification
REQ-030 clk period 10 ns; rst_n low until 10 ns; en=1; clk_meas = clk/4 with 50% duty -> locked after the first rise; meas_valid every 4 cycles with period_out=4, high_out=2.
REQ-031 clk_meas = clk/7, high 3 cycles -> period_out=7, high_out=3, pulse every 7 cycles; first pulse 3 cycles after the second input rise.
REQ-032 TIMEOUT=20; clk_meas stuck at 0 after lock -> timeout pulse exactly 20 cycles after the last rise; locked=0; period_out keeps the prior value.
REQ-033 en dropped for 5 cycles mid-period, then restored -> no meas_valid while low; re-lock on the next rise; the first valid after that is a full, correct period.
REQ-034 rst_n pulsed low between clk edges mid-measurement -> all outputs are 0 immediately; measurement recovers per REQ-029.
REQ-035 Period changed on the fly from clk/4 to clk/6 -> exactly one transitional period_out value, then a steady 6.
